// File: rtl/mem_port_arbiter.sv
// Port-B arbiter for the main BlockRam: fixed CPU priority with a starvation bound for the
// peripheral, one-cycle tagged read return, and the CPU stall signal.
module mem_port_arbiter #(
  parameter int unsigned DATA        = 16,
  parameter int unsigned ADDR        = 14,
  parameter int unsigned MAX_CPU_RUN = 4
) (
  input  logic            i_clk_50mhz,
  input  logic            i_reset,
  // CPU requester
  input  logic            i_cpu_req,
  input  logic            i_cpu_we,
  input  logic [ADDR-1:0] i_cpu_addr,
  input  logic [DATA-1:0] i_cpu_wdata,
  output logic            o_cpu_gnt,
  output logic            o_cpu_stall,
  output logic            o_cpu_rvalid,
  output logic [DATA-1:0] o_cpu_rdata,
  // Peripheral requester
  input  logic            i_per_req,
  input  logic            i_per_we,
  input  logic [ADDR-1:0] i_per_addr,
  input  logic [DATA-1:0] i_per_wdata,
  output logic            o_per_gnt,
  output logic            o_per_rvalid,
  output logic [DATA-1:0] o_per_rdata,
  // BlockRam port B
  output logic            o_mem_we,
  output logic [ADDR-1:0] o_mem_addr,
  output logic [DATA-1:0] o_mem_wdata,
  input  logic [DATA-1:0] i_mem_rdata
);

  localparam logic [3:0] RunMax = 4'(MAX_CPU_RUN);

  logic [3:0] r_run_cnt;
  logic       r_rd_pend;
  logic       r_rd_owner;

  logic       w_cpu_gnt;
  logic       w_per_gnt;
  logic       w_run_full;
  logic [3:0] w_run_cnt_d;

  assign w_run_full = (r_run_cnt >= RunMax);

  always_comb begin
    w_cpu_gnt = 1'b0;
    w_per_gnt = 1'b0;
    if (!i_reset) begin
      if (i_cpu_req && i_per_req) begin
        w_cpu_gnt = !w_run_full;
        w_per_gnt = w_run_full;
      end else begin
        w_cpu_gnt = i_cpu_req;
        w_per_gnt = i_per_req;
      end
    end
  end

  // Counts CPU grants that made a waiting peripheral wait; saturates, never wraps.
  always_comb begin
    w_run_cnt_d = r_run_cnt;
    if (w_per_gnt || !i_per_req) begin
      w_run_cnt_d = 4'd0;
    end else if (w_cpu_gnt && !w_run_full) begin
      w_run_cnt_d = r_run_cnt + 4'd1;
    end
  end

  always_ff @(posedge i_clk_50mhz) begin
    if (i_reset) begin
      r_run_cnt  <= 4'd0;
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
    end else begin
      r_run_cnt  <= w_run_cnt_d;
      r_rd_pend  <= (w_cpu_gnt && !i_cpu_we) || (w_per_gnt && !i_per_we);
      r_rd_owner <= w_per_gnt;
    end
  end

  // With no grant the RAM sees the CPU fields, keeping the address stable.
  always_comb begin
    o_mem_addr  = i_cpu_addr;
    o_mem_wdata = i_cpu_wdata;
    o_mem_we    = w_cpu_gnt && i_cpu_we;
    if (w_per_gnt) begin
      o_mem_addr  = i_per_addr;
      o_mem_wdata = i_per_wdata;
      o_mem_we    = i_per_we;
    end
  end

  assign o_cpu_gnt    = w_cpu_gnt;
  assign o_per_gnt    = w_per_gnt;
  assign o_cpu_stall  = i_cpu_req && !w_cpu_gnt;
  assign o_cpu_rvalid = r_rd_pend && !r_rd_owner;
  assign o_per_rvalid = r_rd_pend && r_rd_owner;
  assign o_cpu_rdata  = i_mem_rdata;
  assign o_per_rdata  = i_mem_rdata;

endmodule
